// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/response, redirect from the
// branch unit and the valid/ready handshake towards decode.
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;
  logic [6:0]      instr_opcode;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, instr_opcode,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, instr_opcode,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order word reads with
// credit-based flow control and buffers returned words for decode.
//
// state   | meaning
// FETCH   | no stale responses pending, returned words go to the buffer
// DROP    | drop_cnt responses from before a redirect still to be discarded
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master fetch_bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic {S_FETCH, S_DROP} state_t;

  state_t           r_state;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_occ;
  logic [XLEN-1:0]  r_pcq [DEPTH];
  logic [PTR_W-1:0] r_pcq_wr;
  logic [PTR_W-1:0] r_pcq_rd;
  logic [XLEN-1:0]  r_buf_pc [DEPTH];
  logic [XLEN-1:0]  r_buf_data [DEPTH];
  logic [PTR_W-1:0] r_buf_wr;
  logic [PTR_W-1:0] r_buf_rd;

  logic             w_redirect;
  logic             w_instr_valid;
  logic             w_pop;
  logic [CNT_W-1:0] w_occ_after;
  logic             w_credit;
  logic             w_req_valid;
  logic             w_accept;
  logic             w_rsp;
  logic             w_push;
  logic [CNT_W-1:0] w_drop_next;
  logic [XLEN-1:0]  w_head_data;

  assign w_redirect    = fetch_bus.redirect_valid;
  assign w_instr_valid = (r_occ != '0);
  assign w_pop         = w_instr_valid && fetch_bus.instr_ready && !w_redirect;
  assign w_occ_after   = r_occ - CNT_W'(w_pop);
  // Reserve a buffer slot for every in-flight request so a response can never overflow.
  assign w_credit      = ({1'b0, r_outstanding} + {1'b0, w_occ_after}) < SUM_W'(DEPTH);
  assign w_req_valid   = rst_n && !w_redirect && w_credit;
  assign w_accept      = w_req_valid && fetch_bus.imem_req_ready;
  assign w_rsp         = fetch_bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_push        = w_rsp && !w_redirect && (r_state == S_FETCH);
  assign w_drop_next   = r_outstanding - CNT_W'(w_rsp);
  assign w_head_data   = r_buf_data[r_buf_rd];

  assign fetch_bus.imem_req_valid = w_req_valid;
  assign fetch_bus.imem_req_addr  = r_fetch_pc;
  assign fetch_bus.instr_valid    = w_instr_valid;
  assign fetch_bus.instr_data     = w_head_data;
  assign fetch_bus.instr_pc       = r_buf_pc[r_buf_rd];
  assign fetch_bus.instr_opcode   = w_head_data[6:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_occ         <= '0;
      r_pcq_wr      <= '0;
      r_pcq_rd      <= '0;
      r_buf_wr      <= '0;
      r_buf_rd      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pcq[i]      <= '0;
        r_buf_pc[i]   <= '0;
        r_buf_data[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_pcq[r_pcq_wr] <= r_fetch_pc;
        r_pcq_wr        <= r_pcq_wr + PTR_W'(1);
      end
      if (w_rsp) begin
        r_pcq_rd <= r_pcq_rd + PTR_W'(1);
      end
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);

      if (w_redirect) begin
        r_fetch_pc <= fetch_bus.redirect_pc & ~XLEN'(3);
        r_occ      <= '0;
        r_buf_wr   <= r_buf_rd;
        r_drop_cnt <= w_drop_next;
        r_state    <= (w_drop_next != '0) ? S_DROP : S_FETCH;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_push) begin
          r_buf_pc[r_buf_wr]   <= r_pcq[r_pcq_rd];
          r_buf_data[r_buf_wr] <= fetch_bus.imem_rsp_data;
          r_buf_wr             <= r_buf_wr + PTR_W'(1);
        end
        if (w_pop) begin
          r_buf_rd <= r_buf_rd + PTR_W'(1);
        end
        r_occ <= r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
        case (r_state)
          S_FETCH: r_state <= S_FETCH;
          S_DROP: begin
            if (w_rsp) begin
              r_drop_cnt <= r_drop_cnt - CNT_W'(1);
              if (r_drop_cnt == CNT_W'(1)) begin
                r_state <= S_FETCH;
              end
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end
endmodule
